// File: rtl/pp_seq_multiplier.sv
// pp_seq_multiplier: sequential shift-add multiplier, one partial product per clock.
// Latency: W cycles from the accept edge to out_valid; one product every W+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake (a = multiplicand, b = multiplier, W bits)
//   out_valid/out_ready result handshake (result = 2W-bit product)
//   busy                high while an operation is in RUN or DONE
//
// Build option: define PP_SEQ_SIGNED_EN for two's complement operands
// (sign-extended multiplicand, MSB partial product subtracted); otherwise unsigned.
module pp_seq_multiplier #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] result,
  output logic           busy
);

`ifdef PP_SEQ_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  localparam int CW = ($clog2(W) > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [2*W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*W-1:0]   pp;
  logic             last_pp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    pp       = mplier_q[0] ? mcand_q : '0;
    last_pp  = (cnt_q == CNT_LAST);

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Sign bit replication collapses to zero-extension in the unsigned build.
          mcand_d  = {{W{SIGNED_EN & a[W-1]}}, a};
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        // In two's complement the multiplier MSB carries weight -2^(W-1),
        // so its partial product is subtracted rather than added.
        if (SIGNED_EN && last_pp) begin
          acc_d = acc_q - pp;
        end else begin
          acc_d = acc_q + pp;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_ONE;
        if (last_pp) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = !in_ready;
  assign result    = acc_q;

endmodule

// File: tb/tb_pp_seq_multiplier.sv
module tb_pp_seq_multiplier;
  localparam int W = 8;
  localparam int PER = 10;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] result;
  logic           busy;

  int tests = 0;
  int fails = 0;

  // Scoreboard: expected products and their accept times, oldest first.
  logic [2*W-1:0] sb_q[$];
  time            acc_tq[$];
  time            t_last_acc;

  // 0: out_ready high, 1: random, 2: held low
  int or_mode = 0;

  pp_seq_multiplier #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #(PER/2) clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: the arithmetic product truncated to 2W bits.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    longint p;
`ifdef PP_SEQ_SIGNED_EN
    p = longint'($signed(x)) * longint'($signed(y));
`else
    p = longint'({1'b0, x}) * longint'({1'b0, y});
`endif
    return p[2*W-1:0];
  endfunction

  // out_ready driver, updated just after each rising edge.
  always @(posedge clk) begin
    #2;
    case (or_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 1) == 1);
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: latency on out_valid rise, stability while held, compare on handshake.
  logic           prev_ov = 1'b0;
  logic [2*W-1:0] prev_res = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (acc_tq.size() == 0) begin
          check("unexpected_out_valid", 64'(1), 64'(0));
        end else begin
          check("latency", 64'(($time - acc_tq.pop_front() - PER/2) / PER), 64'(W));
        end
      end
      if (out_valid && prev_ov) check("result_stable", 64'(result), 64'(prev_res));
      if (out_valid && out_ready) begin
        if (sb_q.size() != 0) check("result", 64'(result), 64'(sb_q.pop_front()));
      end
      prev_ov  = out_valid;
      prev_res = result;
    end
  end

  task automatic send_exp(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2*W-1:0] exp);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      check("in_ready_timeout", 64'(0), 64'(1));
      return;
    end
    a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    t_last_acc = $time;
    sb_q.push_back(exp);
    acc_tq.push_back($time);
    #1 in_valid = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
    send_exp(x, y, model(x, y));
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) check("drain_timeout", 64'(sb_q.size()), 64'(0));
    @(negedge clk);
  endtask

  initial begin
    time t1;
    int n;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed vectors with spec-derived constants.
`ifdef PP_SEQ_SIGNED_EN
    send_exp(8'hFD, 8'h05, 16'hFFF1);
    send_exp(8'h80, 8'h80, 16'h4000);
    send_exp(8'h80, 8'h7F, 16'hC080);
    send_exp(8'hFF, 8'hFF, 16'h0001);
`else
    send_exp(8'hFF, 8'hFF, 16'hFE01);
    send_exp(8'h00, 8'hA5, 16'h0000);
    send_exp(8'hFD, 8'h05, 16'h04F1);
    send_exp(8'h80, 8'h7F, 16'h3F80);
`endif
    drain();

    // Back-to-back with out_ready held high: accepts W+2 cycles apart.
    or_mode = 0;
    send(8'd3, 8'd2);
    t1 = t_last_acc;
    send(8'hFF, 8'hFF);
    check("b2b_spacing", 64'((t_last_acc - t1) / PER), 64'(W + 2));
    drain();

    // Backpressure: result held, new operands ignored while in DONE.
    or_mode = 2;
    send_exp(8'h0C, 8'h0B, 16'h0084);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 a = 8'h55; b = 8'h33; in_valid = 1'b1;
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'(1));
      check("bp_in_ready", 64'(in_ready), 64'(0));
      check("bp_result", 64'(result), 64'(16'h0084));
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    or_mode = 0;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_in_ready", 64'(in_ready), 64'(1));
    check("bp_release_out_valid", 64'(out_valid), 64'(0));

    // Reset during RUN cycle 3.
    send(8'h13, 8'h21);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'(1));
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_result", 64'(result), 64'(0));
    sb_q.delete();
    acc_tq.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'(1));
    send_exp(8'h07, 8'h06, 16'h002A);
    drain();

    // Randomized operands with random output backpressure.
    or_mode = 1;
    for (int i = 0; i < 40; i++) begin
      send(W'($urandom), W'($urandom));
    end
    drain();
    or_mode = 0;
    check("no_extra_outputs", 64'(acc_tq.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
